// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier arbiter/scheduler slice.
package mul_pkg;
    localparam int unsigned EXPO_W = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned W      = 1 + EXPO_W + MANT_W;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned FLAG_W = 5;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [1:0] {
        RTZ = 2'b00,
        RDN = 2'b01,
        RUP = 2'b10,
        RNE = 2'b11
    } rnd_e;

    typedef struct packed {
        logic [W-1:0]      data;
        logic [FLAG_W-1:0] flags;
        logic [ID_W-1:0]   id;
    } rsp_t;
endpackage

// File: rtl/mul_arb_sched_if.sv
// Requester, datapath and response signals of the shared multiplier scheduler.
interface mul_arb_sched_if;
    import mul_pkg::*;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0][W-1:0]  req_a;
    logic [N_REQ-1:0][W-1:0]  req_b;
    rnd_e [N_REQ-1:0]         req_rnd;

    logic                     mul_vld;
    logic [W-1:0]             mul_a;
    logic [W-1:0]             mul_b;
    rnd_e                     mul_rnd;

    logic                     res_vld;
    logic [W-1:0]             res_data;
    logic [FLAG_W-1:0]        res_flags;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [W-1:0]             rsp_data;
    logic [FLAG_W-1:0]        rsp_flags;
    logic [ID_W-1:0]          rsp_id;

    logic                     err_align;

    modport slave (
        input  req_valid, req_a, req_b, req_rnd, res_vld, res_data, res_flags, rsp_ready,
        output req_ready, mul_vld, mul_a, mul_b, mul_rnd,
               rsp_valid, rsp_data, rsp_flags, rsp_id, err_align
    );

    modport master (
        output req_valid, req_a, req_b, req_rnd, res_vld, res_data, res_flags, rsp_ready,
        input  req_ready, mul_vld, mul_a, mul_b, mul_rnd,
               rsp_valid, rsp_data, rsp_flags, rsp_id, err_align
    );
endinterface

// File: rtl/mul_rsp_fifo.sv
// Synchronous response FIFO; push while full is accepted only together with a pop.
module mul_rsp_fifo import mul_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_t             push_data,
    input  logic             pop,
    output rsp_t             head,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mul_arb_sched.sv
// Round-robin, credit-gated sharing of one fixed-latency FP multiplier between requesters.
module mul_arb_sched import mul_pkg::*; #(
    parameter int unsigned LAT       = 3,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_arb_sched_if.slave bus
);
    localparam int unsigned CRD_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned IGN_W = $clog2(LAT + 1);

    logic                       active;
    logic [ID_W-1:0]            rr_ptr;
    logic [CRD_W-1:0]           credits;
    logic                       gnt_vld;
    logic [ID_W-1:0]            gnt_id;
    logic                       issue;
    logic                       pop;

    logic                       mul_vld_q;
    logic [W-1:0]               mul_a_q;
    logic [W-1:0]               mul_b_q;
    rnd_e                       mul_rnd_q;
    logic [ID_W-1:0]            mul_id_q;

    logic [LAT-1:0]             tag_vld;
    logic [LAT-1:0][ID_W-1:0]   tag_id;
    logic                       tag_out_vld;
    logic [IGN_W-1:0]           ign_cnt;
    logic                       err_q;

    rsp_t                       push_data;
    rsp_t                       head;
    logic [CRD_W-1:0]           fifo_cnt;

    // First valid requester at or after rr_ptr, modulo N_REQ
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_vld && bus.req_valid[ID_W'((32'(rr_ptr) + i) % N_REQ)]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign issue = gnt_vld && active && (credits != '0);
    assign pop   = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        bus.req_ready = '0;
        if (issue) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    // active holds req_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            rr_ptr  <= '0;
            credits <= CRD_W'(OUT_DEPTH);
        end else begin
            active <= 1'b1;
            if (issue) begin
                rr_ptr <= (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
            end
            case ({issue, pop})
                2'b10:   credits <= credits - CRD_W'(1);
                2'b01:   credits <= credits + CRD_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Issue register; operands hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_vld_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_rnd_q <= RTZ;
            mul_id_q  <= '0;
        end else begin
            mul_vld_q <= issue;
            if (issue) begin
                mul_a_q   <= bus.req_a[gnt_id];
                mul_b_q   <= bus.req_b[gnt_id];
                mul_rnd_q <= bus.req_rnd[gnt_id];
                mul_id_q  <= gnt_id;
            end
        end
    end

    assign bus.mul_vld = mul_vld_q;
    assign bus.mul_a   = mul_a_q;
    assign bus.mul_b   = mul_b_q;
    assign bus.mul_rnd = mul_rnd_q;

    // Tag pipe mirrors datapath latency so its output lines up with res_vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= mul_vld_q;
            tag_id[0]  <= mul_id_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign tag_out_vld = tag_vld[LAT-1];

    // Results issued before reset may still emerge for LAT cycles; they are not errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ign_cnt <= IGN_W'(LAT);
            err_q   <= 1'b0;
        end else begin
            if (ign_cnt != '0) begin
                ign_cnt <= ign_cnt - IGN_W'(1);
            end
            if ((bus.res_vld != tag_out_vld) && !((ign_cnt != '0) && !tag_out_vld)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err_align = err_q;

    assign push_data.data  = bus.res_data;
    assign push_data.flags = bus.res_flags;
    assign push_data.id    = tag_id[LAT-1];

    mul_rsp_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_out_vld),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_cnt)
    );

    assign bus.rsp_valid = (fifo_cnt != '0);
    assign bus.rsp_data  = head.data;
    assign bus.rsp_flags = head.flags;
    assign bus.rsp_id    = head.id;
endmodule
